// File: rtl/edge_pkg.sv
// Shared widths, window slice offsets and stage payloads for the Sobel edge pipeline.
package edge_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WIN_W     = 72;
  localparam int unsigned HCOUNT_W  = 11;
  localparam int unsigned VCOUNT_W  = 10;
  localparam int unsigned SUM_W     = 10;
  localparam int unsigned GRAD_W    = 11;
  localparam int unsigned MAG_SUM_W = 11;
  localparam int unsigned RGB_W     = 24;

  localparam int unsigned H_ACTIVE_DEF = 1024;
  localparam int unsigned V_ACTIVE_DEF = 768;
  localparam int unsigned CNT_W_DEF    = 20;

  // Row-major window: p0 is the top-left pixel in the most significant byte.
  localparam int unsigned P0_LSB = 64;
  localparam int unsigned P1_LSB = 56;
  localparam int unsigned P2_LSB = 48;
  localparam int unsigned P3_LSB = 40;
  localparam int unsigned P4_LSB = 32;
  localparam int unsigned P5_LSB = 24;
  localparam int unsigned P6_LSB = 16;
  localparam int unsigned P7_LSB = 8;
  localparam int unsigned P8_LSB = 0;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  // Per-pixel controls captured in stage 1 and carried with the pixel.
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic [PIX_W-1:0]    threshold;
    logic                mode;
    logic                mask;
  } pix_ctl_t;

  typedef struct packed {
    logic [SUM_W-1:0] sx_p;
    logic [SUM_W-1:0] sx_n;
    logic [SUM_W-1:0] sy_p;
    logic [SUM_W-1:0] sy_n;
    pix_ctl_t         ctl;
  } s1_t;

  typedef struct packed {
    logic [SUM_W-1:0] abs_gx;
    logic [SUM_W-1:0] abs_gy;
    pix_ctl_t         ctl;
  } s2_t;

  // Clamp the L1 gradient sum to the 8-bit pixel range.
  function automatic logic [PIX_W-1:0] sat_mag(input logic [MAG_SUM_W-1:0] sum);
    return (sum > MAG_SUM_W'(PIX_MAX)) ? PIX_MAX : sum[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_edge_pipe_if.sv
// Window-in / edge-out bus of the Sobel stage; master drives windows, slave is the pipeline.
interface sobel_edge_pipe_if
  import edge_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic                win_valid;
  logic [WIN_W-1:0]    win;
  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic [PIX_W-1:0]    threshold;
  logic                mode;

  logic                edge_valid;
  logic [PIX_W-1:0]    edge_mag;
  logic                edge_bin;
  logic [RGB_W-1:0]    out_rgb;
  logic [HCOUNT_W-1:0] out_hcount;
  logic [CNT_W-1:0]    edge_count;
  logic                count_strobe;

  modport master (
    output win_valid, win, hcount, vcount, threshold, mode,
    input  edge_valid, edge_mag, edge_bin, out_rgb, out_hcount, edge_count, count_strobe
  );

  modport slave (
    input  win_valid, win, hcount, vcount, threshold, mode,
    output edge_valid, edge_mag, edge_bin, out_rgb, out_hcount, edge_count, count_strobe
  );

endinterface

// File: rtl/sobel_kernel_sum.sv
// Weighted 1-2-1 sum of three pixels, one half of a Sobel kernel row/column.
module sobel_kernel_sum
  import edge_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [SUM_W-1:0] sum_c
);

  assign sum_c = SUM_W'(a) + SUM_W'({b, 1'b0}) + SUM_W'(c);

endmodule

// File: rtl/sobel_edge_pipe.sv
// Three-stage Sobel magnitude pipeline with border masking, thresholding and a
// per-frame edge-pixel counter; no backpressure.
module sobel_edge_pipe
  import edge_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
)
(
  input  logic              clock,
  input  logic              reset,
  sobel_edge_pipe_if.slave  bus
);

  localparam logic [HCOUNT_W-1:0] H_LAST  = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST  = VCOUNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  // ---------------- stage 1: kernel half-sums and border mask ----------------
  logic [SUM_W-1:0] sx_p_c;
  logic [SUM_W-1:0] sx_n_c;
  logic [SUM_W-1:0] sy_p_c;
  logic [SUM_W-1:0] sy_n_c;
  logic             mask_c;
  s1_t              s1_c;
  s1_t              s1_q;
  logic             s1_valid_q;

  sobel_kernel_sum u_sx_p (
    .a     (bus.win[P2_LSB +: PIX_W]),
    .b     (bus.win[P5_LSB +: PIX_W]),
    .c     (bus.win[P8_LSB +: PIX_W]),
    .sum_c (sx_p_c)
  );

  sobel_kernel_sum u_sx_n (
    .a     (bus.win[P0_LSB +: PIX_W]),
    .b     (bus.win[P3_LSB +: PIX_W]),
    .c     (bus.win[P6_LSB +: PIX_W]),
    .sum_c (sx_n_c)
  );

  sobel_kernel_sum u_sy_p (
    .a     (bus.win[P6_LSB +: PIX_W]),
    .b     (bus.win[P7_LSB +: PIX_W]),
    .c     (bus.win[P8_LSB +: PIX_W]),
    .sum_c (sy_p_c)
  );

  sobel_kernel_sum u_sy_n (
    .a     (bus.win[P0_LSB +: PIX_W]),
    .b     (bus.win[P1_LSB +: PIX_W]),
    .c     (bus.win[P2_LSB +: PIX_W]),
    .sum_c (sy_n_c)
  );

  always_comb begin
    s1_c   = '0;
    mask_c = (bus.hcount == '0) || (bus.hcount >= H_LAST) ||
             (bus.vcount == '0) || (bus.vcount >= V_LAST);
    s1_c.sx_p          = sx_p_c;
    s1_c.sx_n          = sx_n_c;
    s1_c.sy_p          = sy_p_c;
    s1_c.sy_n          = sy_n_c;
    s1_c.ctl.hcount    = bus.hcount;
    s1_c.ctl.vcount    = bus.vcount;
    s1_c.ctl.threshold = bus.threshold;
    s1_c.ctl.mode      = bus.mode;
    s1_c.ctl.mask      = mask_c;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= bus.win_valid;
      s1_q       <= s1_c;
    end
  end

  // ---------------- stage 2: signed gradients, absolute values ----------------
  logic signed [GRAD_W-1:0] gx_c;
  logic signed [GRAD_W-1:0] gy_c;
  s2_t                      s2_c;
  s2_t                      s2_q;
  logic                     s2_valid_q;

  always_comb begin
    s2_c        = '0;
    gx_c        = $signed({1'b0, s1_q.sx_p}) - $signed({1'b0, s1_q.sx_n});
    gy_c        = $signed({1'b0, s1_q.sy_p}) - $signed({1'b0, s1_q.sy_n});
    s2_c.abs_gx = gx_c[GRAD_W-1] ? SUM_W'(-gx_c) : SUM_W'(gx_c);
    s2_c.abs_gy = gy_c[GRAD_W-1] ? SUM_W'(-gy_c) : SUM_W'(gy_c);
    s2_c.ctl    = s1_q.ctl;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_q       <= s2_c;
    end
  end

  // ---------------- stage 3: magnitude, threshold, display pixel ----------------
  logic [MAG_SUM_W-1:0] mag_sum_c;
  logic [PIX_W-1:0]     mag_c;
  logic                 bin_c;
  logic [RGB_W-1:0]     rgb_c;
  logic                 frame_end_c;

  always_comb begin
    mag_sum_c   = MAG_SUM_W'(s2_q.abs_gx) + MAG_SUM_W'(s2_q.abs_gy);
    mag_c       = s2_q.ctl.mask ? '0 : sat_mag(mag_sum_c);
    bin_c       = !s2_q.ctl.mask && (mag_c >= s2_q.ctl.threshold);
    rgb_c       = s2_q.ctl.mode ? {RGB_W{bin_c}} : {3{mag_c}};
    frame_end_c = s2_valid_q && (s2_q.ctl.hcount == H_LAST) && (s2_q.ctl.vcount == V_LAST);
  end

  logic                edge_valid_q;
  logic [PIX_W-1:0]    edge_mag_q;
  logic                edge_bin_q;
  logic [RGB_W-1:0]    out_rgb_q;
  logic [HCOUNT_W-1:0] out_hcount_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      edge_valid_q <= 1'b0;
      edge_mag_q   <= '0;
      edge_bin_q   <= 1'b0;
      out_rgb_q    <= '0;
      out_hcount_q <= '0;
    end else begin
      edge_valid_q <= s2_valid_q;
      edge_mag_q   <= mag_c;
      edge_bin_q   <= bin_c;
      out_rgb_q    <= rgb_c;
      out_hcount_q <= s2_q.ctl.hcount;
    end
  end

  // Frame counter: the last active pixel is always masked, so publishing and
  // clearing on that beat never loses an increment.
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] edge_count_q;
  logic             count_strobe_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q          <= '0;
      edge_count_q   <= '0;
      count_strobe_q <= 1'b0;
    end else begin
      count_strobe_q <= frame_end_c;
      if (frame_end_c) begin
        edge_count_q <= acc_q;
        acc_q        <= '0;
      end else if (s2_valid_q && bin_c && (acc_q != CNT_MAX)) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end

  assign bus.edge_valid   = edge_valid_q;
  assign bus.edge_mag     = edge_mag_q;
  assign bus.edge_bin     = edge_bin_q;
  assign bus.out_rgb      = out_rgb_q;
  assign bus.out_hcount   = out_hcount_q;
  assign bus.edge_count   = edge_count_q;
  assign bus.count_strobe = count_strobe_q;

endmodule

// File: doc/sobel_edge_pipe.md
Name: sobel_edge_pipe

Overview:
Consumes the 3x3 grayscale window produced by the line-buffer stage and computes the Sobel gradient magnitude per pixel. It produces an 8-bit saturated magnitude, a thresholded binary edge flag and an RGB-replicated display pixel, with border masking. It also keeps a per-frame edge-pixel count for tuning. It sits between the window shift register and the output pixel-select mux, as a 3-stage pipeline with no backpressure.

Parameters:
H_ACTIVE, 1024, active pixels per line; hcount at or above this value is blanking.
V_ACTIVE, 768, active lines per frame; vcount at or above this value is blanking.
CNT_W, 20, width of the edge-count accumulator and its output.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-low; reset==0 on a clock edge clears all state.
win_valid  in  1  the window on win is valid this cycle.
win  in  72  window, row-major: p0=[71:64] top-left ... p4=[39:32] centre ... p8=[7:0] bottom-right.
hcount  in  11  column of the window centre p4, already aligned by the caller.
vcount  in  10  row of the window centre p4.
threshold  in  8  binary edge threshold.
mode  in  1  0 = out_rgb shows magnitude; 1 = out_rgb shows binary (0x000000 or 0xFFFFFF).
edge_valid  out  1  outputs below are valid.
edge_mag  out  8  saturated magnitude.
edge_bin  out  1  1 when edge_mag >= threshold and the pixel is not masked.
out_rgb  out  24  {v,v,v}, where v = edge_mag or the binary value.
out_hcount  out  11  hcount delayed to match the outputs.
edge_count  out  CNT_W  edge pixels counted in the last completed frame.
count_strobe  out  1  one-cycle pulse when edge_count updates.

Behaviour:
- Reset (reset==0): all stage valids, edge_valid, edge_mag, edge_bin, out_rgb, out_hcount, edge_count, count_strobe and the accumulator go to 0. Reset mid-stream drops in-flight pixels, and edge_valid is 0 on the following cycle.
- Latency: exactly 3 clocks from win_valid to edge_valid. Every field (hcount, vcount, threshold, mode, mask) is captured in stage 1 and carried with its pixel. Changing threshold or mode mid-line therefore takes effect per pixel, without tearing.
- Bubbles: win_valid=0 propagates as edge_valid=0. Data regs may hold stale values while invalid; the counter ignores invalid beats.
- Stage 1:
  - sx_p = p2+2*p5+p8 and sx_n = p0+2*p3+p6.
  - sy_p = p6+2*p7+p8 and sy_n = p0+2*p1+p2.
  - Each sum is 10-bit unsigned, max 1020.
  - mask = (hcount==0) or (hcount>=H_ACTIVE-1) or (vcount==0) or (vcount>=V_ACTIVE-1).
- Stage 2: gx = sx_p-sx_n and gy = sy_p-sy_n, 11-bit signed, range -1020..1020. Register |gx| and |gy| as 10-bit unsigned.
- Stage 3:
  - sum = |gx|+|gy|, 11-bit, max 2040.
  - edge_mag = mask ? 0 : (sum>255 ? 255 : sum[7:0]).
  - edge_bin = !mask && (edge_mag >= threshold). With threshold=0, every unmasked pixel gives bin=1.
- Frame counter:
  - On each stage-3 valid beat with edge_bin=1, the accumulator increments, saturating at 2^CNT_W-1.
  - On the valid beat whose carried hcount==H_ACTIVE-1 and vcount==V_ACTIVE-1, edge_count gets the accumulator value (that beat is masked, so it adds nothing). In the same cycle count_strobe=1 and the accumulator clears.
  - Every other cycle, count_strobe=0.
  - If that final beat never arrives (frame aborted), there is no update and the accumulator keeps counting into the next frame.

Decomposition:
- Shared package edge_pkg: PIX_W=8, WIN_W=72, HCOUNT_W=11, VCOUNT_W=10, the p0..p8 slice offsets, and the H_ACTIVE/V_ACTIVE defaults.
- One natural sub-module, sobel_kernel_sum: a purely combinational weighted 1-2-1 sum of three pixels, instantiated four times in stage 1.
- The counter stays inline.

Test Plan:
- Flat window, all nine pixels = 100, hcount=10, vcount=10, threshold=50 -> 3 cycles later edge_valid=1, edge_mag=0, edge_bin=0, out_rgb=0x000000.
- Vertical edge: left column 0, right column 255, centre column 128, mode=1, threshold=128 -> gx=1020, gy=0, edge_mag=255, edge_bin=1, out_rgb=0xFFFFFF.
- Weak gradient: left column 10, right column 20, threshold=50 -> edge_mag=40, edge_bin=0. Then threshold=40 on the next pixel -> edge_bin=1 for that pixel only.
- Border: vertical-edge window at hcount=0, then at vcount=V_ACTIVE-1 -> edge_mag=0, edge_bin=0, edge_valid=1, out_hcount matches the delayed input.
- Bubbles and reset: alternate win_valid 1/0 -> edge_valid shows the same pattern delayed 3 cycles. Assert reset=0 with 3 pixels in flight -> edge_valid=0 next cycle, and edge_count=0.
- Frame count: H_ACTIVE=8, V_ACTIVE=4, edge windows at exactly 5 interior pixels, then the final beat (7,3) -> count_strobe pulses once, edge_count=5. An identical second frame -> edge_count=5 again.
